// File: rtl/hcsr04_multi_ranger.sv
// hcsr04_multi_ranger: sequential trigger/echo timing controller for N ultrasonic rangers.
// Sweeps enabled channels in ascending order, reporting each echo width as a one-cycle record.
module hcsr04_multi_ranger #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int TRIG_CYC = 1,
  parameter int WAIT_MAX = 3000,
  parameter int ECHO_MAX = 6000,
  parameter int HOLDOFF  = 6000,
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             ping_i,
  input  logic             auto_mode_i,
  input  logic [N_CH-1:0]  ch_en_i,
  input  logic [N_CH-1:0]  echo_in_i,
  output logic [N_CH-1:0]  trigger_o,
  output logic             busy_o,
  output logic             meas_valid_o,
  output logic [CH_W-1:0]  meas_ch_o,
  output logic [CNT_W-1:0] meas_count_o,
  output logic             meas_timeout_o,
  output logic             sweep_done_o
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT, ECHO, REPORT, HOLD} state_t;
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] ECHO_SAT  = CNT_W'(ECHO_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
  state_t            state_q;
  logic [N_CH-1:0]   sync_q, echo_s_q, en_q, trigger_q;
  logic [CH_W-1:0]   ch_q, meas_ch_q, first_ch_d, next_ch_d;
  logic [CNT_W-1:0]  cnt_q, meas_count_q;
  logic              busy_q, meas_valid_q, meas_timeout_q, sweep_done_q;
  logic              has_next_d, echo_act;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q   <= '0;
      echo_s_q <= '0;
    end else begin
      sync_q   <= echo_in_i;
      echo_s_q <= sync_q;
    end
  end
  assign echo_act = echo_s_q[ch_q];
  // Descending scans so the lowest qualifying index is the one kept.
  always_comb begin
    first_ch_d = '0;
    next_ch_d  = '0;
    has_next_d = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en_i[i]) first_ch_d = CH_W'(i);
      if (en_q[i] && i > int'(ch_q)) begin
        next_ch_d  = CH_W'(i);
        has_next_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      en_q           <= '0;
      ch_q           <= '0;
      cnt_q          <= '0;
      trigger_q      <= '0;
      busy_q         <= 1'b0;
      meas_valid_q   <= 1'b0;
      meas_ch_q      <= '0;
      meas_count_q   <= '0;
      meas_timeout_q <= 1'b0;
      sweep_done_q   <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      sweep_done_q <= 1'b0;
      case (state_q)
        IDLE: if ((ping_i || auto_mode_i) && |ch_en_i) begin
          en_q      <= ch_en_i;
          ch_q      <= first_ch_d;
          trigger_q <= N_CH'(1) << first_ch_d;
          cnt_q     <= '0;
          busy_q    <= 1'b1;
          state_q   <= TRIG;
        end
        TRIG: if (cnt_q == TRIG_LAST) begin
          trigger_q <= '0;
          cnt_q     <= '0;
          state_q   <= WAIT;
        end else cnt_q <= cnt_q + 1'b1;
        WAIT: if (echo_act) begin
          cnt_q   <= CNT_W'(1);
          state_q <= ECHO;
        end else if (cnt_q == WAIT_LAST) begin
          meas_valid_q   <= 1'b1;
          meas_ch_q      <= ch_q;
          meas_count_q   <= '0;
          meas_timeout_q <= 1'b1;
          state_q        <= REPORT;
        end else cnt_q <= cnt_q + 1'b1;
        ECHO: if (!echo_act || cnt_q == ECHO_SAT) begin
          meas_valid_q   <= 1'b1;
          meas_ch_q      <= ch_q;
          meas_count_q   <= cnt_q;
          meas_timeout_q <= echo_act;
          state_q        <= REPORT;
        end else cnt_q <= cnt_q + 1'b1;
        REPORT: begin
          cnt_q   <= '0;
          state_q <= HOLD;
        end
        HOLD: if (cnt_q == HOLD_LAST) begin
          cnt_q <= '0;
          if (has_next_d) begin
            ch_q      <= next_ch_d;
            trigger_q <= N_CH'(1) << next_ch_d;
            state_q   <= TRIG;
          end else begin
            sweep_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign trigger_o      = trigger_q;
  assign busy_o         = busy_q;
  assign meas_valid_o   = meas_valid_q;
  assign meas_ch_o      = meas_ch_q;
  assign meas_count_o   = meas_count_q;
  assign meas_timeout_o = meas_timeout_q;
  assign sweep_done_o   = sweep_done_q;
endmodule

// File: doc/hcsr04_multi_ranger.md
Name: hcsr04_multi_ranger

Overview:
Parametrised ultrasonic ranging controller for N HC-SR04-style sensors.
- On a ping, or continuously in auto mode, it sweeps the enabled channels in ascending order, one at a time.
- Each channel measurement is: issue a trigger pulse, time the echo high width in clk cycles, apply timeouts, then wait a holdoff before the next channel.
- Each result goes out as a one-cycle valid-qualified record to the downstream distance/BCD display logic.

Parameters:
N_CH, 4, number of sensor channels (1..16); CH_W = max(1, clog2(N_CH)).
CNT_W, 16, width of the echo/wait/holdoff counters and of meas_count.
TRIG_CYC, 1, trigger pulse width in clk cycles (>=1); 1 gives 10 us at 100 kHz.
WAIT_MAX, 3000, max cycles in WAIT for the echo rising edge before timeout (< 2^CNT_W).
ECHO_MAX, 6000, max echo high width in cycles before saturation/timeout (< 2^CNT_W).
HOLDOFF, 6000, idle cycles after each measurement to suppress cross-talk (>=1, < 2^CNT_W).

Ports:
clk  in  1  system clock (100 kHz nominal)
n_rst  in  1  asynchronous active-low reset
ping  in  1  start one sweep; sampled only in IDLE
auto_mode  in  1  1 = start a new sweep from IDLE every time without ping
ch_en  in  N_CH  per-channel enable mask; sampled when a sweep starts
echo_in  in  N_CH  raw echo lines (asynchronous)
trigger  out  N_CH  trigger outputs, at most one high at any time
busy  out  1  high in every state except IDLE
meas_valid  out  1  one-cycle pulse: result fields valid
meas_ch  out  CH_W  channel index of the result
meas_count  out  CNT_W  echo width in clk cycles
meas_timeout  out  1  1 = no echo in WAIT_MAX cycles, or echo saturated at ECHO_MAX
sweep_done  out  1  one-cycle pulse after the holdoff of the last enabled channel

Behaviour:
- Reset: async on n_rst low. State IDLE; trigger=0; busy=0; meas_valid=0; sweep_done=0; meas_ch=0; meas_count=0; meas_timeout=0; counters=0; synchronisers=0. All outputs are registered.
- Echo sync: each echo_in bit passes a 2-FF synchroniser (echo_s). Only echo_s[ch] of the active channel is observed; other channels are ignored.
- States: IDLE, TRIG, WAIT, ECHO, REPORT, HOLD.
- IDLE:
  - If (ping | auto_mode) and ch_en != 0: latch ch_en into en_q, set ch = lowest set bit of en_q, go to TRIG.
  - If ch_en == 0: stay in IDLE, no output activity.
- TRIG:
  - trigger[ch]=1 for exactly TRIG_CYC cycles, starting the cycle after the start condition is sampled.
  - Then go to WAIT with wait_cnt=0.
- WAIT:
  - If echo_s[ch]=1: go to ECHO with echo_cnt=1.
  - Else if wait_cnt == WAIT_MAX-1: go to REPORT with result count=0, timeout=1.
  - Else wait_cnt+1.
- ECHO:
  - If echo_s[ch]=0: go to REPORT with count=echo_cnt, timeout=0.
  - Else if echo_cnt == ECHO_MAX: go to REPORT with count=ECHO_MAX, timeout=1.
  - Else echo_cnt+1.
  - Net effect: an echo high for W cycles (W <= ECHO_MAX) reports exactly W.
- REPORT (1 cycle):
  - meas_valid=1; meas_ch, meas_count, meas_timeout update in the same cycle and hold until the next REPORT.
  - Go to HOLD with hold_cnt=0.
- HOLD:
  - All triggers low; echo ignored.
  - On hold_cnt == HOLDOFF-1: if a higher-index bit is set in en_q, ch = next set bit and go to TRIG; else pulse sweep_done=1 for 1 cycle and go to IDLE.
- Continuous mode: with auto_mode=1, the next sweep's TRIG begins the cycle after IDLE is re-entered, giving 1 IDLE cycle between sweeps.
- Ignored inputs:
  - ping outside IDLE is ignored, not queued.
  - ch_en changes mid-sweep have no effect until the next sweep.
- Reset mid-operation: trigger drops immediately (async). No meas_valid or sweep_done is issued for the aborted measurement.
- Counters never wrap, because terminal compares bound them below 2^CNT_W.

Test Plan:
All scenarios use N_CH=2, CNT_W=8, TRIG_CYC=2, WAIT_MAX=20, ECHO_MAX=200, HOLDOFF=10.
- Single channel: ch_en=01, pulse ping, drive echo_in[0] high 37 cycles after a 5-cycle delay -> trigger[0] high 2 cycles; meas_valid once with meas_ch=0, meas_count=37, meas_timeout=0; sweep_done 10 cycles after REPORT; busy falls with return to IDLE.
- Two-channel sweep: ch_en=11, echo widths 12 and 90 -> reports (ch0, 12, 0) then (ch1, 90, 0); trigger[1] rises 10 cycles after the ch0 REPORT; exactly one sweep_done.
- No echo: ch_en=10, echo_in held low -> one report (ch1, 0, timeout=1) 20 cycles after the trigger ends; trigger[0] never asserts.
- Saturation: echo held high 300 cycles -> report count=200, timeout=1; HOLD runs, with no second report from the echo tail.
- Auto and ignore rules: auto_mode=1, ch_en=01 -> back-to-back sweeps with 1 IDLE cycle between. ping pulsed during ECHO -> no extra sweep. ch_en=00 -> busy stays 0.
- Reset mid-ECHO: n_rst low for 1 cycle -> trigger=0, all outputs at reset values; a new ping produces a clean measurement.
